// File: rtl/red_centroid_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : red_centroid_detect
//  Purpose  : Counts red RGB565 pixels over a video frame and, on each frame
//             end, divides the coordinate sums by the count to publish the
//             centroid of the red region with a fixed 30-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module red_centroid_detect #(
    parameter int unsigned R_MIN      = 20,
    parameter int unsigned G_MAX      = 24,
    parameter int unsigned B_MAX      = 12,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic [15:0] rgb565,
    input  logic        v_sync,
    output logic [15:0] x_real_out,
    output logic [15:0] y_real_out,
    output logic        red_detect_out,
    output logic        frame_valid,
    output logic [18:0] pixel_count_out,
    output logic        overrun
);

    localparam logic [9:0]  X_LAST    = 10'd639;
    localparam logic [9:0]  Y_LAST    = 10'd479;
    localparam logic [27:0] X_CLAMP   = 28'd639;
    localparam logic [27:0] Y_CLAMP   = 28'd479;
    localparam logic [4:0]  ITER_LAST = 5'd27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        v_sync_q;
    logic [27:0] sum_x_q, sum_y_q;
    logic [18:0] count_q;
    logic [27:0] quo_x_q, quo_y_q;
    logic [18:0] rem_x_q, rem_y_q;
    logic [18:0] divisor_q;
    logic [4:0]  iter_q;
    logic [15:0] x_out_q, y_out_q;
    logic        detect_q, fvalid_q, overrun_q;
    logic [18:0] pcount_q;

    // Pixel classification: in-frame coordinates and all three colour tests.
    logic [4:0]  w_r5, w_b5;
    logic [5:0]  w_g6;
    logic        w_is_red, w_frame_end, w_start;
    assign w_r5 = rgb565[15:11];
    assign w_g6 = rgb565[10:5];
    assign w_b5 = rgb565[4:0];
    assign w_is_red = pix_valid && (x_pixel <= X_LAST) && (y_pixel <= Y_LAST)
                      && ({27'd0, w_r5} >= R_MIN)
                      && ({26'd0, w_g6} <= G_MAX)
                      && ({27'd0, w_b5} <= B_MAX);

    assign w_frame_end = v_sync && !v_sync_q;
    assign w_start     = w_frame_end && (state_q == S_IDLE);

    // One restoring step for each axis; divisor is shared.
    logic [19:0] w_trial_x, w_trial_y;
    logic        w_ge_x, w_ge_y;
    assign w_trial_x = {rem_x_q, quo_x_q[27]};
    assign w_trial_y = {rem_y_q, quo_y_q[27]};
    assign w_ge_x    = w_trial_x >= {1'b0, divisor_q};
    assign w_ge_y    = w_trial_y >= {1'b0, divisor_q};

    // Result selection: clamp to the visible area, qualify by pixel count.
    logic        w_enough;
    logic [15:0] w_x_res, w_y_res;
    assign w_enough = {13'd0, divisor_q} >= MIN_PIXELS;
    assign w_x_res  = (quo_x_q > X_CLAMP) ? 16'd639 : quo_x_q[15:0];
    assign w_y_res  = (quo_y_q > Y_CLAMP) ? 16'd479 : quo_y_q[15:0];

    // Frame-sync edge register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) v_sync_q <= 1'b0;
        else       v_sync_q <= v_sync;
    end

    // Accumulators: cleared at frame end, a pixel arriving that cycle starts the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            count_q <= '0;
        end else begin
            sum_x_q <= (w_frame_end ? 28'd0 : sum_x_q) + (w_is_red ? {18'd0, x_pixel} : 28'd0);
            sum_y_q <= (w_frame_end ? 28'd0 : sum_y_q) + (w_is_red ? {18'd0, y_pixel} : 28'd0);
            count_q <= (w_frame_end ? 19'd0 : count_q) + {18'd0, w_is_red};
        end
    end

    // Divider state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Divider next-state: start on an idle frame end, 28 iterations, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_frame_end) state_d = S_DIV;
            S_DIV:   if (iter_q == ITER_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider datapath: snapshot operands on start, then one quotient bit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_x_q   <= '0;
            quo_y_q   <= '0;
            rem_x_q   <= '0;
            rem_y_q   <= '0;
            divisor_q <= '0;
            iter_q    <= '0;
        end else if (w_start) begin
            quo_x_q   <= sum_x_q;
            quo_y_q   <= sum_y_q;
            rem_x_q   <= '0;
            rem_y_q   <= '0;
            divisor_q <= count_q;
            iter_q    <= '0;
        end else if (state_q == S_DIV) begin
            // The remainder stays below the divisor, so 19 bits hold it exactly.
            rem_x_q <= w_ge_x ? (w_trial_x[18:0] - divisor_q) : w_trial_x[18:0];
            rem_y_q <= w_ge_y ? (w_trial_y[18:0] - divisor_q) : w_trial_y[18:0];
            quo_x_q <= {quo_x_q[26:0], w_ge_x};
            quo_y_q <= {quo_y_q[26:0], w_ge_y};
            iter_q  <= iter_q + 5'd1;
        end
    end

    // Output registers: publish in DONE, strobe frame_valid, flag dropped frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out_q   <= 16'd320;
            y_out_q   <= 16'd240;
            detect_q  <= 1'b0;
            fvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            pcount_q  <= '0;
        end else begin
            fvalid_q  <= (state_q == S_DONE);
            overrun_q <= w_frame_end && (state_q != S_IDLE);
            if (state_q == S_DONE) begin
                pcount_q <= divisor_q;
                detect_q <= w_enough;
                if (w_enough) begin
                    x_out_q <= w_x_res;
                    y_out_q <= w_y_res;
                end
            end
        end
    end

    assign x_real_out      = x_out_q;
    assign y_real_out      = y_out_q;
    assign red_detect_out  = detect_q;
    assign frame_valid     = fvalid_q;
    assign pixel_count_out = pcount_q;
    assign overrun         = overrun_q;

endmodule
`default_nettype wire
